// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic peripherals: FSM state encoding and default operand widths.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int DIVISOR_W = 16
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] diff;

    // The partial remainder stays below the divisor, so the shifted value fits in
    // DIVISOR_W+1 bits and the extra top bit of the difference acts as the borrow.
    always_comb begin
        diff    = {rem_in, bit_in} - {2'b00, divisor};
        q_bit   = ~diff[DIVISOR_W+1];
        rem_out = q_bit ? diff[DIVISOR_W:0] : {rem_in[DIVISOR_W-1:0], bit_in};
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with start/busy/done handshake.
module divider
    import arith_pkg::*;
#(
    parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = arith_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] work;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;
    logic                  accept;

    div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .rem_in (rem_q),
        .bit_in (work[DIVIDEND_W-1]),
        .divisor(divisor_q),
        .rem_out(rem_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = (state == CALC);
        done       = (state == DONE);
        case (state)
            IDLE, DONE: begin
                accept = start;
                if (start) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The working register shifts dividend bits out of the top while quotient bits
    // enter at the bottom, so after the last step it holds the full quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            work        <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend[DIVISOR_W-1:0];
                div_by_zero <= 1'b1;
            end else begin
                work      <= dividend;
                divisor_q <= divisor;
                rem_q     <= '0;
                count     <= CNT_W'(DIVIDEND_W - 1);
            end
        end else if (state == CALC) begin
            work  <= {work[DIVIDEND_W-2:0], q_bit};
            rem_q <= rem_next;
            count <= count - CNT_W'(1);
            if (count == '0) begin
                quotient    <= {work[DIVIDEND_W-2:0], q_bit};
                remainder   <= rem_next[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the sequential divider: latency, results, handshake and reset abort.
module tb_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and counts cycles (sampled on negedges, 0 = cycle after the
    // start edge) until done, also counting busy cycles and any busy/done overlap.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] ds,
                          output int cycles, output int busy_cycles, output bit overlap);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = ds;
        @(negedge clk);
        start       = 1'b0;
        cycles      = 0;
        busy_cycles = 0;
        overlap     = 1'b0;
        while (!done && cycles < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 51'd0)
            $display("[TB] FAIL reset_values: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc, bcyc;
        bit ov;
        run_op(32'd100, 16'd7, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 32) $display("[TB] FAIL basic_latency: got %0d, want 32", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bcyc !== 32) $display("[TB] FAIL basic_busy_cycles: got %0d, want 32", bcyc);
        else pass_cnt++;
        total_cnt++;
        if (ov) $display("[TB] FAIL basic_busy_done_overlap: got 1, want 0");
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 32'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0)
            $display("[TB] FAIL basic_result: q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || quotient !== 32'd14)
            $display("[TB] FAIL basic_done_pulse: done=%b q=%0d, want done=0 q=14", done, quotient);
        else pass_cnt++;
    endtask

    task automatic test_extreme();
        int cyc, bcyc;
        bit ov;
        run_op(32'hFFFF_FFFF, 16'hFFFF, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'h0001_0001 || remainder !== 16'h0000)
            $display("[TB] FAIL extreme_max_max: cyc=%0d q=%h r=%h, want cyc=32 q=00010001 r=0000",
                     cyc, quotient, remainder);
        else pass_cnt++;
        run_op(32'hFFFF_FFFF, 16'h0001, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 16'h0000)
            $display("[TB] FAIL extreme_max_one: cyc=%0d q=%h r=%h, want cyc=32 q=ffffffff r=0000",
                     cyc, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_small();
        int cyc, bcyc;
        bit ov;
        run_op(32'd5, 16'd10, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'd0 || remainder !== 16'd5)
            $display("[TB] FAIL small_dividend: cyc=%0d q=%0d r=%0d, want cyc=32 q=0 r=5",
                     cyc, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int cyc, bcyc;
        bit ov;
        run_op(32'h1234_5678, 16'h0000, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 0) $display("[TB] FAIL dbz_latency: got %0d, want 0", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bcyc !== 0 || busy !== 1'b0)
            $display("[TB] FAIL dbz_busy: busy_cycles=%0d busy=%b, want 0 and 0", bcyc, busy);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 16'h5678 || div_by_zero !== 1'b1)
            $display("[TB] FAIL dbz_result: q=%h r=%h dbz=%b, want q=ffffffff r=5678 dbz=1",
                     quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || div_by_zero !== 1'b1)
            $display("[TB] FAIL dbz_hold: done=%b dbz=%b, want done=0 dbz=1", done, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (cyc == 5) begin
                total_cnt++;
                if (quotient !== 32'hFFFF_FFFF || div_by_zero !== 1'b1)
                    $display("[TB] FAIL calc_outputs_hold: q=%h dbz=%b, want q=ffffffff dbz=1",
                             quotient, div_by_zero);
                else pass_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'd333 || remainder !== 16'd1 || div_by_zero !== 1'b0)
            $display("[TB] FAIL start_in_calc_ignored: cyc=%0d q=%0d r=%0d dbz=%b, want cyc=32 q=333 r=1 dbz=0",
                     cyc, quotient, remainder, div_by_zero);
        else pass_cnt++;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 16'd2;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL accept_in_done: busy=%b done=%b, want busy=1 done=0", busy, done);
        else pass_cnt++;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'd4 || remainder !== 16'd1)
            $display("[TB] FAIL back_to_back_result: cyc=%0d q=%0d r=%0d, want cyc=32 q=4 r=1",
                     cyc, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int cyc, bcyc;
        bit ov;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 51'd0)
            $display("[TB] FAIL reset_mid_calc: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL reset_no_done: busy=%b done=%b, want 0 and 0", busy, done);
        else pass_cnt++;
        run_op(32'd50, 16'd5, cyc, bcyc, ov);
        total_cnt++;
        if (cyc !== 32 || quotient !== 32'd10 || remainder !== 16'd0)
            $display("[TB] FAIL after_reset_op: cyc=%0d q=%0d r=%0d, want cyc=32 q=10 r=0",
                     cyc, quotient, remainder);
        else pass_cnt++;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_extreme();
        test_small();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
